// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial audio link (transmitter and receiver sides).
// Pure declarations: no logic, no latency.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } link_state_t;

    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset level.
// Latency: 2 clk cycles; no flow control.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// Oversampling UART-style byte receiver (start, 8 data LSB first, [even parity with SERIAL_RX_PARITY_EN], stop).
// Latency: strobe lands HALF_BIT + (9 or 10)*CLKS_PER_BIT + 1 cycles after IDLE sees the start edge; no backpressure.
module serial_byte_receiver
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset,
    input  logic                 Serial_In,
    output logic [DATA_BITS-1:0] Parallel_Data,
    output logic                 Data_Valid,
    output logic                 Framing_Error,
`ifdef SERIAL_RX_PARITY_EN
    output logic                 Parity_Error,
`endif
    output logic                 Busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int IW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rx;
    link_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [DATA_BITS-1:0] pd_q, pd_n;
    logic                 dv_q, dv_n;
    logic                 fe_q, fe_n;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bad, par_bad_n;
    logic                 pe_q, pe_n;
`endif

    sync_2ff #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk  (CLOCK_50),
        .rst  (Reset),
        .din  (Serial_In),
        .dout (rx)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        pd_n    = pd_q;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_n = par_bad;
        pe_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx != IDLE_LEVEL) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = (rx == IDLE_LEVEL) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx, sh[DATA_BITS-1:1]};
                    idx_n = idx + 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = (rx != ^sh);
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx == IDLE_LEVEL) begin
                        state_n = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (par_bad) begin
                            pe_n = 1'b1;
                        end else begin
                            dv_n = 1'b1;
                            pd_n = sh;
                        end
`else
                        dv_n = 1'b1;
                        pd_n = sh;
`endif
                    end else begin
                        // Framing error wins over parity; park until the line is released.
                        fe_n    = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx == IDLE_LEVEL) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            pd_q  <= '0;
            dv_q  <= 1'b0;
            fe_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            pd_q  <= pd_n;
            dv_q  <= dv_n;
            fe_q  <= fe_n;
`ifdef SERIAL_RX_PARITY_EN
            par_bad <= par_bad_n;
            pe_q    <= pe_n;
`endif
        end
    end

    assign Parallel_Data = pd_q;
    assign Data_Valid    = dv_q;
    assign Framing_Error = fe_q;
`ifdef SERIAL_RX_PARITY_EN
    assign Parity_Error  = pe_q;
`endif
    assign Busy          = (state != IDLE);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver at CLKS_PER_BIT=8: table-driven frames, corner sequences,
// and random frames checked against a frame-level event model.
module tb_serial_byte_receiver;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Line change -> 2 sync flops -> IDLE decision edge, then half bit, then data/parity/stop bits.
    localparam int LAT   = 3 + HALF + (9 + NPAR) * CPB;
    localparam int NV    = 5 + NPAR;
    localparam int EV_DV = 1;
    localparam int EV_FE = 2;
    localparam int EV_PE = 3;

    typedef struct {
        int         kind;
        int         at;
        logic [7:0] dat;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       pflip;
        int         low_after;
        int         gap;
        int         exp_kind;
        logic [7:0] exp_pd;
    } vec_t;

    logic       CLOCK_50  = 1'b0;
    logic       Reset     = 1'b1;
    logic       Serial_In = 1'b1;
    logic [7:0] Parallel_Data;
    logic       Data_Valid;
    logic       Framing_Error;
    logic       Busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       Parity_Error;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    ev_t        got[$];
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;

    serial_byte_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .Reset         (Reset),
        .Serial_In     (Serial_In),
        .Parallel_Data (Parallel_Data),
        .Data_Valid    (Data_Valid),
        .Framing_Error (Framing_Error),
`ifdef SERIAL_RX_PARITY_EN
        .Parity_Error  (Parity_Error),
`endif
        .Busy          (Busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (!Reset) begin
            mon_e.at  = cyc;
            mon_e.dat = Parallel_Data;
            if (Data_Valid) begin
                mon_e.kind = EV_DV;
                got.push_back(mon_e);
            end
            if (Framing_Error) begin
                mon_e.kind = EV_FE;
                got.push_back(mon_e);
            end
`ifdef SERIAL_RX_PARITY_EN
            if (Parity_Error) begin
                mon_e.kind = EV_PE;
                got.push_back(mon_e);
            end
`endif
        end
    end

    task automatic chk(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic idle(input int n);
        Serial_In = 1'b1;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic drive_bit(input logic b);
        Serial_In = b;
        repeat (CPB) @(negedge CLOCK_50);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                              output int start);
        start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (NPAR != 0) drive_bit((^d) ^ pflip);
        drive_bit(stop);
    endtask

    function automatic void model_frame(input int start, input logic [7:0] d,
                                        input logic stop, input logic pflip);
        ev_t e;
        e.at = start + LAT;
        if (!stop) begin
            e.kind = EV_FE;
            e.dat  = last_good;
        end else if (pflip && NPAR != 0) begin
            e.kind = EV_PE;
            e.dat  = last_good;
        end else begin
            e.kind    = EV_DV;
            e.dat     = d;
            last_good = d;
        end
        exp_q.push_back(e);
    endfunction

    task automatic compare_events(input string tag);
        chk({tag, " event count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s ev%0d kind", tag, i), got[i].kind, exp_q[i].kind);
            chk($sformatf("%s ev%0d cycle", tag, i), got[i].at, exp_q[i].at);
            chk($sformatf("%s ev%0d data", tag, i), int'(got[i].dat), int'(exp_q[i].dat));
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int         st;
        logic [7:0] rd;
        logic       rstop, rflip;
        vec_t       tbl[NV];
        ev_t        e;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 0,  12, EV_DV, 8'hA5};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 20, 12, EV_FE, 8'hA5};
        tbl[2] = '{8'h5A, 1'b1, 1'b0, 0,  12, EV_DV, 8'h5A};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 0,  0,  EV_DV, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 0,  12, EV_DV, 8'hFF};
`ifdef SERIAL_RX_PARITY_EN
        tbl[5] = '{8'h07, 1'b1, 1'b1, 0,  12, EV_PE, 8'hFF};
`endif

        Reset     = 1'b1;
        Serial_In = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("reset Parallel_Data", int'(Parallel_Data), 0);
        chk("reset Data_Valid", int'(Data_Valid), 0);
        chk("reset Framing_Error", int'(Framing_Error), 0);
        chk("reset Busy", int'(Busy), 0);
`ifdef SERIAL_RX_PARITY_EN
        chk("reset Parity_Error", int'(Parity_Error), 0);
`endif
        Reset = 1'b0;
        idle(4);

        // Low pulse shorter than half a bit must be rejected at the start-bit centre.
        Serial_In = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("glitch Busy asserted", int'(Busy), 1);
        idle(8);
        chk("glitch Busy released", int'(Busy), 0);
        compare_events("glitch");

        for (int i = 0; i < NV; i++) begin
            send_frame(tbl[i].d, tbl[i].stop, tbl[i].pflip, st);
            e.kind = tbl[i].exp_kind;
            e.at   = st + LAT;
            e.dat  = tbl[i].exp_pd;
            exp_q.push_back(e);
            last_good = tbl[i].exp_pd;
            if (tbl[i].low_after > 0) begin
                Serial_In = 1'b0;
                repeat (tbl[i].low_after) @(negedge CLOCK_50);
                chk("break Busy held", int'(Busy), 1);
            end
            idle(tbl[i].gap);
        end
        chk("table idle Busy", int'(Busy), 0);
        compare_events("table");

        // Reset during data bit 4 of 0x81 abandons the frame.
        rd = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rd[i]);
        Serial_In = rd[4];
        repeat (4) @(negedge CLOCK_50);
        Reset = 1'b1;
        @(negedge CLOCK_50);
        chk("midreset Busy", int'(Busy), 0);
        chk("midreset Parallel_Data", int'(Parallel_Data), 0);
        chk("midreset Data_Valid", int'(Data_Valid), 0);
        chk("midreset Framing_Error", int'(Framing_Error), 0);
        Reset     = 1'b0;
        last_good = 8'h00;
        idle(3 * CPB);
        chk("midreset Busy after release", int'(Busy), 0);
        compare_events("midreset");
        send_frame(8'h81, 1'b1, 1'b0, st);
        model_frame(st, 8'h81, 1'b1, 1'b0);
        idle(10);
        compare_events("after reset");

        for (int n = 0; n < 40; n++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rflip = ($urandom_range(0, 3) == 0);
            send_frame(rd, rstop, rflip, st);
            model_frame(st, rd, rstop, rflip);
            if (!rstop) begin
                Serial_In = 1'b0;
                repeat ($urandom_range(0, 10)) @(negedge CLOCK_50);
                idle($urandom_range(1, 15));
            end else begin
                idle($urandom_range(0, 15));
            end
        end
        idle(15);
        compare_events("random");
        chk("final Parallel_Data", int'(Parallel_Data), int'(last_good));
        chk("final Busy", int'(Busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
